// File: rtl/sordm5_keyboard.sv
// ---------------------------------------------------------------------------
// sordm5_keyboard
// Turns MiST ps2_key edge events into the Sord M5 7x8 keyboard matrix that the
// console core samples on ports 0x30..0x36. Pressed/released state is held per
// matrix position, because ps2_key only reports edges.
//
// Pipeline: S0 capture on toggle change -> S1 ROM lookup -> S2 matrix update.
// Outputs are registered from the matrix one cycle after S2.
//
// Ports
//   clk_i        system clock (clk_sys)
//   reset_n_i    synchronous active-low reset
//   ps2_key_i    [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   clear_i      synchronous release-all (download / OSD reset)
//   row_sel_i    matrix row being read by the core
//   row_o        selected row, 1 = pressed (registered)
//   reset_key_o  high while F12 is held
//   any_key_o    OR of all matrix bits (registered)
// ---------------------------------------------------------------------------
module sordm5_keyboard #(
   parameter int ROWS = 7
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic [10:0] ps2_key_i,
   input  logic        clear_i,
   input  logic [2:0]  row_sel_i,
   output logic [7:0]  row_o,
   output logic        reset_key_o,
   output logic        any_key_o
);

   localparam logic [3:0] ROWS_W = 4'(ROWS);

   // S0
   logic       last_tgl_q, last_tgl_d;
   logic       ev_v_q, ev_v_d;
   logic [9:0] ev_q, ev_d;            // {pressed, ext, code}

   // S1
   logic       lk_v_q, lk_v_d;
   logic       lk_pressed_q, lk_pressed_d;
   logic       lk_valid_q, lk_valid_d;
   logic [2:0] lk_row_q, lk_row_d;
   logic [2:0] lk_col_q, lk_col_d;
   logic       lk_f12_q, lk_f12_d;

   // S2 / outputs
   logic [ROWS-1:0][7:0] mat_q, mat_d;
   logic                 reset_key_q, reset_key_d;
   logic [7:0]           row_q, row_d;
   logic                 any_key_q, any_key_d;

   // ROM result {valid, row, col}
   logic [6:0] rom;
   logic       rom_f12;

   always_comb begin
      rom     = 7'h00;
      rom_f12 = 1'b0;
      case (ev_q[8:0])
         // row 0: modifiers, space, return
         9'h014, 9'h114: rom = {1'b1, 3'd0, 3'd0};
         9'h011, 9'h111: rom = {1'b1, 3'd0, 3'd1};
         9'h012:         rom = {1'b1, 3'd0, 3'd2};
         9'h059:         rom = {1'b1, 3'd0, 3'd3};
         9'h029:         rom = {1'b1, 3'd0, 3'd6};
         9'h05A, 9'h15A: rom = {1'b1, 3'd0, 3'd7};
         // row 1: 1..8
         9'h016: rom = {1'b1, 3'd1, 3'd0};
         9'h01E: rom = {1'b1, 3'd1, 3'd1};
         9'h026: rom = {1'b1, 3'd1, 3'd2};
         9'h025: rom = {1'b1, 3'd1, 3'd3};
         9'h02E: rom = {1'b1, 3'd1, 3'd4};
         9'h036: rom = {1'b1, 3'd1, 3'd5};
         9'h03D: rom = {1'b1, 3'd1, 3'd6};
         9'h03E: rom = {1'b1, 3'd1, 3'd7};
         // row 2: Q W E R T Y U I
         9'h015: rom = {1'b1, 3'd2, 3'd0};
         9'h01D: rom = {1'b1, 3'd2, 3'd1};
         9'h024: rom = {1'b1, 3'd2, 3'd2};
         9'h02D: rom = {1'b1, 3'd2, 3'd3};
         9'h02C: rom = {1'b1, 3'd2, 3'd4};
         9'h035: rom = {1'b1, 3'd2, 3'd5};
         9'h03C: rom = {1'b1, 3'd2, 3'd6};
         9'h043: rom = {1'b1, 3'd2, 3'd7};
         // row 3: A S D F G H J K
         9'h01C: rom = {1'b1, 3'd3, 3'd0};
         9'h01B: rom = {1'b1, 3'd3, 3'd1};
         9'h023: rom = {1'b1, 3'd3, 3'd2};
         9'h02B: rom = {1'b1, 3'd3, 3'd3};
         9'h034: rom = {1'b1, 3'd3, 3'd4};
         9'h033: rom = {1'b1, 3'd3, 3'd5};
         9'h03B: rom = {1'b1, 3'd3, 3'd6};
         9'h042: rom = {1'b1, 3'd3, 3'd7};
         // row 4: Z X C V B N M ,
         9'h01A: rom = {1'b1, 3'd4, 3'd0};
         9'h022: rom = {1'b1, 3'd4, 3'd1};
         9'h021: rom = {1'b1, 3'd4, 3'd2};
         9'h02A: rom = {1'b1, 3'd4, 3'd3};
         9'h032: rom = {1'b1, 3'd4, 3'd4};
         9'h031: rom = {1'b1, 3'd4, 3'd5};
         9'h03A: rom = {1'b1, 3'd4, 3'd6};
         9'h041: rom = {1'b1, 3'd4, 3'd7};
         // row 5: 9 0 - ^(=) yen(\) O P @([)
         9'h046: rom = {1'b1, 3'd5, 3'd0};
         9'h045: rom = {1'b1, 3'd5, 3'd1};
         9'h04E: rom = {1'b1, 3'd5, 3'd2};
         9'h055: rom = {1'b1, 3'd5, 3'd3};
         9'h05D: rom = {1'b1, 3'd5, 3'd4};
         9'h044: rom = {1'b1, 3'd5, 3'd5};
         9'h04D: rom = {1'b1, 3'd5, 3'd6};
         9'h054: rom = {1'b1, 3'd5, 3'd7};
         // row 6: L ; :(') ](]) . / _(`) ESC
         9'h04B: rom = {1'b1, 3'd6, 3'd0};
         9'h04C: rom = {1'b1, 3'd6, 3'd1};
         9'h052: rom = {1'b1, 3'd6, 3'd2};
         9'h05B: rom = {1'b1, 3'd6, 3'd3};
         9'h049: rom = {1'b1, 3'd6, 3'd4};
         9'h04A: rom = {1'b1, 3'd6, 3'd5};
         9'h00E: rom = {1'b1, 3'd6, 3'd6};
         9'h076: rom = {1'b1, 3'd6, 3'd7};
         9'h007: rom_f12 = 1'b1;
         default: rom = 7'h00;
      endcase
   end

   always_comb begin
      // S0: a toggle change is always consumed, even while clearing, so a
      // dropped event is never replayed afterwards.
      last_tgl_d = ps2_key_i[10];
      ev_d       = ev_q;
      if (ps2_key_i[10] != last_tgl_q)
         ev_d = ps2_key_i[9:0];
      ev_v_d     = (ps2_key_i[10] != last_tgl_q) && !clear_i;

      // S1
      lk_v_d       = ev_v_q && !clear_i;
      lk_pressed_d = ev_q[9];
      lk_valid_d   = rom[6];
      lk_row_d     = rom[5:3];
      lk_col_d     = rom[2:0];
      lk_f12_d     = rom_f12;

      // S2: clear beats a same-cycle update
      mat_d       = mat_q;
      reset_key_d = reset_key_q;
      if (clear_i) begin
         mat_d       = '0;
         reset_key_d = 1'b0;
      end else if (lk_v_q) begin
         if (lk_valid_q && ({1'b0, lk_row_q} < ROWS_W))
            mat_d[lk_row_q][lk_col_q] = lk_pressed_q;
         if (lk_f12_q)
            reset_key_d = lk_pressed_q;
      end

      // read side
      row_d     = ({1'b0, row_sel_i} < ROWS_W) ? mat_q[row_sel_i] : 8'h00;
      any_key_d = |mat_q;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         last_tgl_q   <= ps2_key_i[10];
         ev_v_q       <= 1'b0;
         ev_q         <= '0;
         lk_v_q       <= 1'b0;
         lk_pressed_q <= 1'b0;
         lk_valid_q   <= 1'b0;
         lk_row_q     <= '0;
         lk_col_q     <= '0;
         lk_f12_q     <= 1'b0;
         mat_q        <= '0;
         reset_key_q  <= 1'b0;
         row_q        <= 8'h00;
         any_key_q    <= 1'b0;
      end else begin
         last_tgl_q   <= last_tgl_d;
         ev_v_q       <= ev_v_d;
         ev_q         <= ev_d;
         lk_v_q       <= lk_v_d;
         lk_pressed_q <= lk_pressed_d;
         lk_valid_q   <= lk_valid_d;
         lk_row_q     <= lk_row_d;
         lk_col_q     <= lk_col_d;
         lk_f12_q     <= lk_f12_d;
         mat_q        <= mat_d;
         reset_key_q  <= reset_key_d;
         row_q        <= row_d;
         any_key_q    <= any_key_d;
      end
   end

   assign row_o       = row_q;
   assign reset_key_o = reset_key_q;
   assign any_key_o   = any_key_q;

endmodule

// File: tb/tb_sordm5_keyboard.sv
// ---------------------------------------------------------------------------
// Directed bench for sordm5_keyboard. Inputs change 1 ns after a rising edge;
// outputs are sampled 1 ns after a rising edge. A key event sent right after
// edge N is expected on row_o/any_key_o after edge N+4 and on reset_key_o
// after edge N+3.
// ---------------------------------------------------------------------------
module tb_sordm5_keyboard;

   logic        clk_i;
   logic        reset_n_i;
   logic [10:0] ps2_key_i;
   logic        clear_i;
   logic [2:0]  row_sel_i;
   logic [7:0]  row_o;
   logic        reset_key_o;
   logic        any_key_o;

   int errors = 0;
   int checks = 0;
   logic tgl;

   sordm5_keyboard #(.ROWS(7)) dut (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .ps2_key_i   (ps2_key_i),
      .clear_i     (clear_i),
      .row_sel_i   (row_sel_i),
      .row_o       (row_o),
      .reset_key_o (reset_key_o),
      .any_key_o   (any_key_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
      tgl = ~tgl;
      ps2_key_i = {tgl, pressed, ext, code};
   endtask

   task automatic read_row(input logic [2:0] r, output logic [7:0] v);
      row_sel_i = r;
      tick(1);
      v = row_o;
   endtask

   task automatic test_reset;
      logic [7:0] v;
      reset_n_i = 1'b0;
      ps2_key_i = 11'h400;
      tgl = 1'b1;
      tick(4);
      reset_n_i = 1'b1;
      tick(10);
      for (int r = 0; r < 8; r++) begin
         read_row(3'(r), v);
         checks++;
         if (v !== 8'h00) begin
            errors++;
            $display("FAIL reset_row%0d: got %h expected 00", r, v);
         end
      end
      checks++;
      if (any_key_o !== 1'b0 || reset_key_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: any=%b rk=%b expected 0 0", any_key_o, reset_key_o);
      end
      // A stale toggle present during reset must not be replayed as a press.
      reset_n_i = 1'b0;
      ps2_key_i = 11'h21C;
      tgl = 1'b0;
      tick(2);
      ps2_key_i = 11'h61C;
      tgl = 1'b1;
      tick(2);
      reset_n_i = 1'b1;
      row_sel_i = 3'd3;
      tick(10);
      checks++;
      if (row_o !== 8'h00 || any_key_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_event: row3=%h any=%b expected 00 0", row_o, any_key_o);
      end
   endtask

   task automatic test_reset_midpipe;
      send(1'b1, 1'b0, 8'h1C);
      tick(1);
      reset_n_i = 1'b0;
      tick(2);
      reset_n_i = 1'b1;
      row_sel_i = 3'd3;
      tick(6);
      checks++;
      if (row_o !== 8'h00 || any_key_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_midpipe: row3=%h any=%b expected 00 0", row_o, any_key_o);
      end
   endtask

   task automatic test_make_break;
      row_sel_i = 3'd3;
      tick(1);
      send(1'b1, 1'b0, 8'h1C);
      tick(3);
      checks++;
      if (row_o !== 8'h00) begin
         errors++;
         $display("FAIL make_early: row3=%h expected 00 at N+3", row_o);
      end
      tick(1);
      checks++;
      if (row_o !== 8'h01) begin
         errors++;
         $display("FAIL make_row: row3=%h expected 01 at N+4", row_o);
      end
      checks++;
      if (any_key_o !== 1'b1) begin
         errors++;
         $display("FAIL make_any: got %b expected 1", any_key_o);
      end
      // repeated make is idempotent
      send(1'b1, 1'b0, 8'h1C);
      tick(5);
      checks++;
      if (row_o !== 8'h01) begin
         errors++;
         $display("FAIL make_repeat: row3=%h expected 01", row_o);
      end
      send(1'b0, 1'b0, 8'h1C);
      tick(4);
      checks++;
      if (row_o !== 8'h00 || any_key_o !== 1'b0) begin
         errors++;
         $display("FAIL break: row3=%h any=%b expected 00 0", row_o, any_key_o);
      end
      // break of a released key is idempotent
      send(1'b0, 1'b0, 8'h1C);
      tick(5);
      checks++;
      if (row_o !== 8'h00 || any_key_o !== 1'b0) begin
         errors++;
         $display("FAIL break_repeat: row3=%h any=%b expected 00 0", row_o, any_key_o);
      end
   endtask

   task automatic test_ext_unmapped;
      logic [7:0] v;
      logic [7:0] exp_rows [8];
      row_sel_i = 3'd0;
      send(1'b1, 1'b1, 8'h5A);
      tick(4);
      checks++;
      if (row_o !== 8'h80) begin
         errors++;
         $display("FAIL ext_return: row0=%h expected 80", row_o);
      end
      send(1'b1, 1'b1, 8'h75);
      tick(5);
      exp_rows = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int r = 0; r < 8; r++) begin
         read_row(3'(r), v);
         checks++;
         if (v !== exp_rows[r]) begin
            errors++;
            $display("FAIL unmapped_row%0d: got %h expected %h", r, v, exp_rows[r]);
         end
      end
      // plain 0x5A release shares the RETURN position
      send(1'b0, 1'b0, 8'h5A);
      row_sel_i = 3'd0;
      tick(5);
      checks++;
      if (row_o !== 8'h00) begin
         errors++;
         $display("FAIL return_release: row0=%h expected 00", row_o);
      end
   endtask

   task automatic test_keymap;
      logic [7:0] v;
      send(1'b1, 1'b0, 8'h15);   // Q   row2 b0
      tick(1);
      send(1'b1, 1'b0, 8'h76);   // ESC row6 b7
      tick(1);
      send(1'b1, 1'b0, 8'h4E);   // -   row5 b2
      tick(1);
      send(1'b1, 1'b0, 8'h45);   // 0   row5 b1
      tick(1);
      send(1'b1, 1'b1, 8'h14);   // E0 CTRL row0 b0
      tick(5);
      read_row(3'd2, v);
      checks++;
      if (v !== 8'h01) begin
         errors++;
         $display("FAIL map_row2: got %h expected 01", v);
      end
      read_row(3'd6, v);
      checks++;
      if (v !== 8'h80) begin
         errors++;
         $display("FAIL map_row6: got %h expected 80", v);
      end
      read_row(3'd5, v);
      checks++;
      if (v !== 8'h06) begin
         errors++;
         $display("FAIL map_row5: got %h expected 06", v);
      end
      read_row(3'd0, v);
      checks++;
      if (v !== 8'h01) begin
         errors++;
         $display("FAIL map_row0: got %h expected 01", v);
      end
      read_row(3'd7, v);
      checks++;
      if (v !== 8'h00) begin
         errors++;
         $display("FAIL map_row7: got %h expected 00", v);
      end
      clear_i = 1'b1;
      tick(1);
      clear_i = 1'b0;
      tick(2);
      checks++;
      if (any_key_o !== 1'b0) begin
         errors++;
         $display("FAIL map_clear_any: got %b expected 0", any_key_o);
      end
   endtask

   task automatic test_back_to_back;
      row_sel_i = 3'd1;
      send(1'b1, 1'b0, 8'h16);
      tick(1);
      send(1'b1, 1'b0, 8'h1E);
      tick(1);
      send(1'b0, 1'b0, 8'h16);
      tick(4);
      checks++;
      if (row_o !== 8'h02) begin
         errors++;
         $display("FAIL back_to_back: row1=%h expected 02", row_o);
      end
      send(1'b0, 1'b0, 8'h1E);
      tick(5);
      checks++;
      if (row_o !== 8'h00 || any_key_o !== 1'b0) begin
         errors++;
         $display("FAIL b2b_release: row1=%h any=%b expected 00 0", row_o, any_key_o);
      end
   endtask

   task automatic test_clear_collision;
      row_sel_i = 3'd0;
      send(1'b1, 1'b0, 8'h29);
      tick(2);
      clear_i = 1'b1;            // event sits in S2 for the next edge
      tick(1);
      clear_i = 1'b0;
      tick(3);
      checks++;
      if (row_o !== 8'h00 || any_key_o !== 1'b0) begin
         errors++;
         $display("FAIL clear_collision: row0=%h any=%b expected 00 0", row_o, any_key_o);
      end
      send(1'b1, 1'b0, 8'h29);
      tick(4);
      checks++;
      if (row_o !== 8'h40) begin
         errors++;
         $display("FAIL after_clear_press: row0=%h expected 40", row_o);
      end
      send(1'b0, 1'b0, 8'h29);
      tick(5);
      // an event arriving while clear is high is dropped, not replayed
      row_sel_i = 3'd3;
      clear_i = 1'b1;
      send(1'b1, 1'b0, 8'h1C);
      tick(1);
      clear_i = 1'b0;
      tick(6);
      checks++;
      if (row_o !== 8'h00 || any_key_o !== 1'b0) begin
         errors++;
         $display("FAIL clear_drop: row3=%h any=%b expected 00 0", row_o, any_key_o);
      end
   endtask

   task automatic test_f12;
      send(1'b1, 1'b0, 8'h07);
      tick(2);
      checks++;
      if (reset_key_o !== 1'b0) begin
         errors++;
         $display("FAIL f12_early: got %b expected 0 at N+2", reset_key_o);
      end
      tick(1);
      checks++;
      if (reset_key_o !== 1'b1) begin
         errors++;
         $display("FAIL f12_press: got %b expected 1 at N+3", reset_key_o);
      end
      tick(2);
      checks++;
      if (any_key_o !== 1'b0) begin
         errors++;
         $display("FAIL f12_no_matrix: any=%b expected 0", any_key_o);
      end
      send(1'b0, 1'b0, 8'h07);
      tick(3);
      checks++;
      if (reset_key_o !== 1'b0) begin
         errors++;
         $display("FAIL f12_release: got %b expected 0", reset_key_o);
      end
      send(1'b1, 1'b1, 8'h07);
      tick(4);
      checks++;
      if (reset_key_o !== 1'b0 || any_key_o !== 1'b0) begin
         errors++;
         $display("FAIL f12_ext: rk=%b any=%b expected 0 0", reset_key_o, any_key_o);
      end
      send(1'b1, 1'b0, 8'h07);
      tick(4);
      clear_i = 1'b1;
      tick(1);
      clear_i = 1'b0;
      checks++;
      if (reset_key_o !== 1'b0) begin
         errors++;
         $display("FAIL f12_clear: got %b expected 0", reset_key_o);
      end
   endtask

   initial begin
      reset_n_i = 1'b0;
      ps2_key_i = 11'h400;
      clear_i   = 1'b0;
      row_sel_i = 3'd0;
      tgl       = 1'b1;
      #1;
      test_reset;
      test_reset_midpipe;
      test_make_break;
      test_ext_unmapped;
      test_keymap;
      test_back_to_back;
      test_clear_collision;
      test_f12;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
